sonic_vc_rx_fifo_p0_adapter: RTL and testbench

Avalon-ST timing adapter for the SoNIC virtual-channel receive path. It accepts 128-bit beats from the RX datapath, which has no backpressure, and buffers them in a small FIFO. It presents them downstream on a ready/valid (ready latency 0) source. On overflow it drops traffic at packet granularity and closes any truncated packet with an error-tagged terminator beat, so the downstream parser never sees an unterminated packet.

---
 rtl/sonic_vc_rx_fifo_p0_adapter_if.sv | 29 ++
 rtl/sonic_vc_rx_fifo_p0_adapter.sv | 161 ++++++++++++++++
 tb/tb_sonic_vc_rx_fifo_p0_adapter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonic_vc_rx_fifo_p0_adapter_if.sv
// Avalon-ST style bundle for the SoNIC VC receive FIFO adapter: RX beat input
// (no backpressure) and ready/valid output toward the downstream parser.
interface sonic_vc_rx_fifo_p0_adapter_if;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_error;
   logic         in_startofpacket;
   logic         in_endofpacket;
   logic [1:0]   in_empty;
   logic         out_ready;
   logic         out_valid;
   logic [127:0] out_data;
   logic         out_error;
   logic         out_startofpacket;
   logic         out_endofpacket;
   logic [1:0]   out_empty;

   modport master (
      output in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
      output out_ready,
      input  out_valid, out_data, out_error, out_startofpacket, out_endofpacket, out_empty
   );

   modport slave (
      input  in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
      input  out_ready,
      output out_valid, out_data, out_error, out_startofpacket, out_endofpacket, out_empty
   );
endinterface

// File: rtl/sonic_vc_rx_fifo_p0_adapter.sv
// Show-ahead FIFO between the non-stallable RX datapath and a ready/valid sink;
// overflow drops whole packets and closes truncated ones with an error terminator.
//
//   state  | meaning
//   PASS   | normal operation, beats written while space remains
//   DROP   | discarding the remainder of a packet whose start was lost
//   TERM   | packet truncated, waiting for space to write the error terminator
module sonic_vc_rx_fifo_p0_adapter #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sonic_vc_rx_fifo_p0_adapter_if.slave st,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [CNT_W-1:0]         drop_count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 133;
   localparam logic [AW:0]       FULL      = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [EW-1:0]     TERM_BEAT = {128'd0, 1'b1, 1'b0, 1'b1, 2'd0};

   typedef enum logic [1:0] {S_PASS, S_DROP, S_TERM} state_e;

   state_e            state_q, state_d;
   logic              eop_seen_q, eop_seen_d;
   logic              in_pkt_q, in_pkt_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fill_q, fill_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     mem_d [DEPTH];

   logic              space, pop, push, discard, resync, pass_like;
   logic              in_sop, in_eop, in_vld;
   logic [EW-1:0]     wr_entry;

   assign in_vld    = st.in_valid;
   assign in_sop    = st.in_startofpacket;
   assign in_eop    = st.in_endofpacket;
   // Space is judged on the registered count only, so a pop never frees room for a same-cycle push.
   assign space     = fill_q < FULL;
   assign pop       = (fill_q != '0) && st.out_ready;
   assign resync    = (state_q == S_DROP) && in_vld && in_sop;
   assign pass_like = (state_q == S_PASS) || resync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_PASS;
         eop_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         eop_seen_q <= eop_seen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      eop_seen_d = eop_seen_q;
      case (state_q)
         S_PASS, S_DROP: begin
            if (pass_like && in_vld) begin
               if (space)         state_d = S_PASS;
               else if (in_sop)   state_d = in_eop ? S_PASS : S_DROP;
               else if (in_pkt_q) begin
                  state_d    = S_TERM;
                  eop_seen_d = in_eop;
               end
            end else if ((state_q == S_DROP) && in_vld && in_eop) begin
               state_d = S_PASS;
            end
         end
         S_TERM: begin
            if (in_vld && in_eop) eop_seen_d = 1'b1;
            if (space) begin
               state_d    = (eop_seen_q || (in_vld && in_eop)) ? S_PASS : S_DROP;
               eop_seen_d = 1'b0;
            end
         end
         default: state_d = S_PASS;
      endcase
   end

   always_comb begin
      push     = 1'b0;
      discard  = 1'b0;
      ovf_d    = 1'b0;
      in_pkt_d = in_pkt_q;
      wr_entry = {st.in_data, st.in_error, in_sop, in_eop, st.in_empty};
      case (state_q)
         S_TERM: begin
            discard = in_vld;
            if (space) begin
               push     = 1'b1;
               wr_entry = TERM_BEAT;
               in_pkt_d = 1'b0;
            end
         end
         default: begin
            if (in_vld) begin
               if (pass_like && space) begin
                  push = 1'b1;
                  if (in_eop)      in_pkt_d = 1'b0;
                  else if (in_sop) in_pkt_d = 1'b1;
               end else begin
                  discard = 1'b1;
                  ovf_d   = (state_q == S_PASS);
               end
            end
         end
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      drop_d   = drop_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_entry;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   fill_d = fill_q + (AW+1)'(1);
         2'b01:   fill_d = fill_q - (AW+1)'(1);
         default: fill_d = fill_q;
      endcase
      if (discard && (drop_q != CNT_MAX)) drop_d = drop_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_pkt_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         mem_q    <= '{default: '0};
      end else begin
         in_pkt_q <= in_pkt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         mem_q    <= mem_d;
      end
   end

   assign {st.out_data, st.out_error, st.out_startofpacket, st.out_endofpacket, st.out_empty} = mem_q[rd_ptr_q];
   assign st.out_valid = (fill_q != '0);
   assign fill_level   = fill_q;
   assign drop_count   = drop_q;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_sonic_vc_rx_fifo_p0_adapter.sv
// Directed bench for the SoNIC VC RX FIFO adapter: streaming, wrap, overflow,
// truncation terminator, TERM-to-DROP recovery and async reset.
module tb_sonic_vc_rx_fifo_p0_adapter;
   logic         clk;
   logic         reset_n;
   logic [3:0]   fill_level;
   logic [15:0]  drop_count;
   logic         overflow;
   logic [132:0] head;
   int           n_vec;
   int           n_err;

   localparam logic [132:0] TERM_BEAT = {128'd0, 1'b1, 1'b0, 1'b1, 2'd0};

   sonic_vc_rx_fifo_p0_adapter_if st_if ();

   sonic_vc_rx_fifo_p0_adapter #(.DEPTH(8), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .st         (st_if),
      .fill_level (fill_level),
      .drop_count (drop_count),
      .overflow   (overflow)
   );

   assign head = {st_if.out_data, st_if.out_error, st_if.out_startofpacket,
                  st_if.out_endofpacket, st_if.out_empty};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [132:0] beat(input logic [127:0] d, input logic sop, input logic eop,
                                         input logic err, input logic [1:0] emp);
      return {d, err, sop, eop, emp};
   endfunction

   // Presents one beat for exactly one rising edge; returns at the following negedge.
   task automatic drive(input logic [127:0] d, input logic sop, input logic eop,
                        input logic err, input logic [1:0] emp);
      st_if.in_valid         = 1'b1;
      st_if.in_data          = d;
      st_if.in_startofpacket = sop;
      st_if.in_endofpacket   = eop;
      st_if.in_error         = err;
      st_if.in_empty         = emp;
      @(negedge clk);
      st_if.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset;
      st_if.in_valid  = 1'b0;
      st_if.out_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n                = 1'b0;
      st_if.in_valid         = 1'b0;
      st_if.in_data          = '0;
      st_if.in_error         = 1'b0;
      st_if.in_startofpacket = 1'b0;
      st_if.in_endofpacket   = 1'b0;
      st_if.in_empty         = 2'd0;
      st_if.out_ready        = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0h exp=0", st_if.out_valid); end
      n_vec++; if (head !== 133'd0) begin n_err++; $display("FAIL reset_head got=%0h exp=0", head); end
      n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
      n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%0h exp=0", st_if.out_valid); end
   endtask

   task automatic test_streaming;
      apply_reset();
      st_if.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(128'(i), 1'b1, 1'b1, (i == 7), 2'(i));
         n_vec++; if (head !== beat(128'(i), 1'b1, 1'b1, (i == 7), 2'(i))) begin n_err++; $display("FAIL stream_head[%0d] got=%0h exp=%0h", i, head, beat(128'(i), 1'b1, 1'b1, (i == 7), 2'(i))); end
         n_vec++; if (fill_level !== 4'd1) begin n_err++; $display("FAIL stream_fill[%0d] got=%0d exp=1", i, fill_level); end
      end
      idle(1);
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained got=%0h exp=0", st_if.out_valid); end
      n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL stream_drop got=%0d exp=0", drop_count); end
   endtask

   task automatic test_backpressure_wrap;
      logic [132:0] exp_q[$];
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(128'(100 + i), 1'b1, 1'b1, 1'b0, 2'd0);
         exp_q.push_back(beat(128'(100 + i), 1'b1, 1'b1, 1'b0, 2'd0));
         n_vec++; if (fill_level !== 4'(i + 1)) begin n_err++; $display("FAIL bp_fill[%0d] got=%0d exp=%0d", i, fill_level, i + 1); end
         n_vec++; if (st_if.out_data !== 128'd100) begin n_err++; $display("FAIL bp_stall_head[%0d] got=%0h exp=64", i, st_if.out_data); end
      end
      idle(2);
      n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL bp_stable got=%0h exp=%0h", head, exp_q[0]); end
      st_if.out_ready = 1'b1;
      n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL bp_first got=%0h exp=%0h", head, exp_q[0]); end
      void'(exp_q.pop_front());
      idle(1);
      for (int j = 0; j < 8; j++) begin
         n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL bp_wrap[%0d] got=%0h exp=%0h", j, head, exp_q[0]); end
         void'(exp_q.pop_front());
         exp_q.push_back(beat(128'(108 + j), 1'b1, 1'b1, 1'b0, 2'd0));
         drive(128'(108 + j), 1'b1, 1'b1, 1'b0, 2'd0);
         n_vec++; if (fill_level !== 4'd7) begin n_err++; $display("FAIL bp_wrap_fill[%0d] got=%0d exp=7", j, fill_level); end
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         if (st_if.out_valid) begin
            n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL bp_drain got=%0h exp=%0h", head, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain_timeout got=%0d left exp=0", exp_q.size()); end
      n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL bp_final_fill got=%0d exp=0", fill_level); end
      n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL bp_drop got=%0d exp=0", drop_count); end
   endtask

   task automatic test_sop_overflow;
      logic [132:0] exp_q[$];
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(128'(200 + i), 1'b1, 1'b1, 1'b0, 2'd0);
         exp_q.push_back(beat(128'(200 + i), 1'b1, 1'b1, 1'b0, 2'd0));
      end
      n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL so_full got=%0d exp=8", fill_level); end
      drive(128'hA1, 1'b1, 1'b0, 1'b0, 2'd0);
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL so_ovf_pulse got=%0h exp=1", overflow); end
      n_vec++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL so_drop1 got=%0d exp=1", drop_count); end
      drive(128'hA2, 1'b0, 1'b0, 1'b0, 2'd0);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL so_ovf_drop got=%0h exp=0", overflow); end
      drive(128'hA3, 1'b0, 1'b1, 1'b0, 2'd1);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL so_ovf_eop got=%0h exp=0", overflow); end
      n_vec++; if (drop_count !== 16'd3) begin n_err++; $display("FAIL so_drop3 got=%0d exp=3", drop_count); end
      st_if.out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         if (st_if.out_valid) begin
            n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL so_drain got=%0h exp=%0h", head, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL so_drain_timeout got=%0d left exp=0", exp_q.size()); end
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL so_no_leak got=%0h exp=0", st_if.out_valid); end
   endtask

   task automatic test_truncation;
      logic [132:0] exp_q[$];
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(128'(300 + i), 1'b1, 1'b1, 1'b0, 2'd0);
         exp_q.push_back(beat(128'(300 + i), 1'b1, 1'b1, 1'b0, 2'd0));
      end
      for (int b = 0; b < 6; b++) begin
         drive(128'(400 + b), (b == 0), (b == 5), 1'b0, 2'd0);
         if (b < 4) exp_q.push_back(beat(128'(400 + b), (b == 0), 1'b0, 1'b0, 2'd0));
         if (b == 4) begin
            n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL tr_ovf got=%0h exp=1", overflow); end
         end
      end
      exp_q.push_back(TERM_BEAT);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL tr_ovf_term got=%0h exp=0", overflow); end
      n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL tr_fill got=%0d exp=8", fill_level); end
      n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL tr_drop got=%0d exp=2", drop_count); end
      idle(2);
      st_if.out_ready = 1'b1;
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         if (st_if.out_valid) begin
            n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL tr_drain got=%0h exp=%0h", head, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL tr_drain_timeout got=%0d left exp=0", exp_q.size()); end
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL tr_empty got=%0h exp=0", st_if.out_valid); end
      n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL tr_drop_final got=%0d exp=2", drop_count); end
   endtask

   task automatic test_term_then_drop;
      logic [132:0] exp_q[$];
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(128'(500 + i), 1'b1, 1'b1, 1'b0, 2'd0);
         exp_q.push_back(beat(128'(500 + i), 1'b1, 1'b1, 1'b0, 2'd0));
      end
      drive(128'd600, 1'b1, 1'b0, 1'b0, 2'd0);
      drive(128'd601, 1'b0, 1'b0, 1'b0, 2'd0);
      exp_q.push_back(beat(128'd600, 1'b1, 1'b0, 1'b0, 2'd0));
      exp_q.push_back(beat(128'd601, 1'b0, 1'b0, 1'b0, 2'd0));
      exp_q.push_back(TERM_BEAT);
      drive(128'd602, 1'b0, 1'b0, 1'b0, 2'd0);
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL td_ovf got=%0h exp=1", overflow); end
      st_if.out_ready = 1'b1;
      n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL td_pop_head got=%0h exp=%0h", head, exp_q[0]); end
      void'(exp_q.pop_front());
      drive(128'd603, 1'b0, 1'b0, 1'b0, 2'd0);
      st_if.out_ready = 1'b0;
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL td_ovf_term got=%0h exp=0", overflow); end
      n_vec++; if (fill_level !== 4'd7) begin n_err++; $display("FAIL td_fill7 got=%0d exp=7", fill_level); end
      idle(1);
      n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL td_term_written got=%0d exp=8", fill_level); end
      drive(128'd604, 1'b0, 1'b1, 1'b0, 2'd2);
      n_vec++; if (drop_count !== 16'd3) begin n_err++; $display("FAIL td_drop got=%0d exp=3", drop_count); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL td_ovf_drop got=%0h exp=0", overflow); end
      n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL td_fill_after_drop got=%0d exp=8", fill_level); end
      st_if.out_ready = 1'b1;
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         if (st_if.out_valid) begin
            n_vec++; if (head !== exp_q[0]) begin n_err++; $display("FAIL td_drain got=%0h exp=%0h", head, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL td_drain_timeout got=%0d left exp=0", exp_q.size()); end
      for (int b = 0; b < 3; b++) begin
         drive(128'(700 + b), (b == 0), (b == 2), 1'b0, 2'(b));
         n_vec++; if (head !== beat(128'(700 + b), (b == 0), (b == 2), 1'b0, 2'(b))) begin n_err++; $display("FAIL td_next_pkt[%0d] got=%0h exp=%0h", b, head, beat(128'(700 + b), (b == 0), (b == 2), 1'b0, 2'(b))); end
      end
      idle(1);
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL td_empty got=%0h exp=0", st_if.out_valid); end
      n_vec++; if (drop_count !== 16'd3) begin n_err++; $display("FAIL td_drop_final got=%0d exp=3", drop_count); end
   endtask

   task automatic test_async_reset;
      apply_reset();
      for (int i = 0; i < 8; i++) drive(128'(900 + i), 1'b1, 1'b1, 1'b0, 2'd0);
      drive(128'd950, 1'b1, 1'b1, 1'b0, 2'd0);
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ar_ovf got=%0h exp=1", overflow); end
      st_if.out_ready = 1'b1;
      idle(4);
      st_if.out_ready = 1'b0;
      drive(128'd960, 1'b1, 1'b0, 1'b0, 2'd0);
      n_vec++; if (fill_level !== 4'd5) begin n_err++; $display("FAIL ar_fill5 got=%0d exp=5", fill_level); end
      n_vec++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL ar_drop1 got=%0d exp=1", drop_count); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got=%0h exp=0", st_if.out_valid); end
      n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL ar_fill got=%0d exp=0", fill_level); end
      n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL ar_drop got=%0d exp=0", drop_count); end
      n_vec++; if (head !== 133'd0) begin n_err++; $display("FAIL ar_head got=%0h exp=0", head); end
      @(negedge clk);
      reset_n = 1'b1;
      idle(3);
      n_vec++; if (st_if.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_no_term got=%0h exp=0", st_if.out_valid); end
      drive(128'd970, 1'b1, 1'b1, 1'b0, 2'd3);
      n_vec++; if (head !== beat(128'd970, 1'b1, 1'b1, 1'b0, 2'd3)) begin n_err++; $display("FAIL ar_after got=%0h exp=%0h", head, beat(128'd970, 1'b1, 1'b1, 1'b0, 2'd3)); end
      n_vec++; if (fill_level !== 4'd1) begin n_err++; $display("FAIL ar_after_fill got=%0d exp=1", fill_level); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_streaming();
      test_backpressure_wrap();
      test_sop_overflow();
      test_truncation();
      test_term_then_drop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
